sprite_index_fetch: RTL and testbench

SPRITE_INDEX_FETCH -- requirements
Module: sprite_index_fetch

---
 rtl/kof_sprite_pkg.sv | 22 ++
 rtl/sprite_anim_ctrl.sv | 95 +++++++++
 rtl/sprite_index_fetch.sv | 112 +++++++++++
 tb/tb_sprite_index_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/kof_sprite_pkg.sv
// Shared constants and types for the sprite index fetch block and its animation controller.
package kof_sprite_pkg;

    localparam logic [3:0] TRANSPARENT_IDX = 4'hF;

    localparam int DEF_SPR_W           = 64;
    localparam int DEF_SPR_H           = 96;
    localparam int DEF_NUM_FRAMES      = 4;
    localparam int DEF_TICKS_PER_FRAME = 6;
    localparam int DEF_ADDR_W          = 15;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } anim_state_t;

    // Counter width that stays at least one bit for degenerate counts of 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Hit-animation sequencer: steps through stored frames on frame_start pulses and
// publishes the frame to display, latched only at vertical blank.
module sprite_anim_ctrl
    import kof_sprite_pkg::*;
#(
    parameter int NUM_FRAMES      = DEF_NUM_FRAMES,
    parameter int TICKS_PER_FRAME = DEF_TICKS_PER_FRAME,
    parameter int FRAME_W         = clog2_min1(DEF_NUM_FRAMES)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               i_frame_start,
    input  logic               i_hit_trig,
    output logic [FRAME_W-1:0] o_disp_frame,
    output logic               o_anim_busy
);

    localparam int TICK_W = clog2_min1(TICKS_PER_FRAME);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(TICKS_PER_FRAME - 1);

    anim_state_t        r_state;
    logic [FRAME_W-1:0] r_frame_idx;
    logic [TICK_W-1:0]  r_tick;
    logic [FRAME_W-1:0] r_disp_frame;

    anim_state_t        w_state_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [TICK_W-1:0]  w_tick_nxt;
    logic [FRAME_W-1:0] w_disp_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_frame_idx  <= '0;
            r_tick       <= '0;
            r_disp_frame <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_idx  <= w_frame_nxt;
            r_tick       <= w_tick_nxt;
            r_disp_frame <= w_disp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame_idx;
        w_tick_nxt  = r_tick;
        w_disp_nxt  = r_disp_frame;

        case (r_state)
            IDLE: begin
                w_frame_nxt = '0;
                w_tick_nxt  = '0;
                if (i_hit_trig) begin
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                // A retrigger restarts the sequence and suppresses any coincident advance.
                if (i_hit_trig) begin
                    w_frame_nxt = '0;
                    w_tick_nxt  = '0;
                end else if (i_frame_start) begin
                    if (r_tick == LAST_TICK) begin
                        w_tick_nxt = '0;
                        if (r_frame_idx == LAST_FRAME) begin
                            w_state_nxt = IDLE;
                            w_frame_nxt = '0;
                        end else begin
                            w_frame_nxt = r_frame_idx + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_frame_nxt = '0;
                w_tick_nxt  = '0;
            end
        endcase

        // Latching only at vertical blank keeps one frame per scanned picture.
        if (i_frame_start) begin
            w_disp_nxt = w_frame_nxt;
        end
    end

    assign o_disp_frame = r_disp_frame;
    assign o_anim_busy  = (r_state == PLAY);

endmodule

// File: rtl/sprite_index_fetch.sv
// Maps the beam position onto the animated sprite's index ROM and returns the
// palette index three clocks later, with mirroring and transparency applied.
module sprite_index_fetch
    import kof_sprite_pkg::*;
#(
    parameter int SPR_W           = DEF_SPR_W,
    parameter int SPR_H           = DEF_SPR_H,
    parameter int NUM_FRAMES      = DEF_NUM_FRAMES,
    parameter int TICKS_PER_FRAME = DEF_TICKS_PER_FRAME,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_start,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip,
    input  logic              hit_trig,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_valid,
    output logic              anim_busy
);

    localparam int FRAME_W   = clog2_min1(NUM_FRAMES);
    localparam int FRAME_PIX = SPR_W * SPR_H;

    logic [FRAME_W-1:0] w_disp_frame;
    logic [10:0]        w_dx;
    logic [10:0]        w_dy;
    logic               w_in_x;
    logic               w_in_y;
    logic               w_inbox;
    logic [ADDR_W-1:0]  w_col;
    logic [ADDR_W-1:0]  w_row_off;
    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_pix_vld;

    logic [ADDR_W-1:0]  r_rom_addr_p1;
    logic               r_vld_p1;
    logic               r_vld_p2;
    logic [3:0]         r_pix_index_p3;
    logic               r_pix_valid_p3;

    sprite_anim_ctrl #(
        .NUM_FRAMES      (NUM_FRAMES),
        .TICKS_PER_FRAME (TICKS_PER_FRAME),
        .FRAME_W         (FRAME_W)
    ) u_anim (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .i_frame_start (frame_start),
        .i_hit_trig    (hit_trig),
        .o_disp_frame  (w_disp_frame),
        .o_anim_busy   (anim_busy)
    );

    // Offsets use 11 bits so a sprite hanging past column 1023 never wraps into view.
    always_comb begin
        w_dx      = {1'b0, DrawX} - {1'b0, sprite_x};
        w_dy      = {1'b0, DrawY} - {1'b0, sprite_y};
        w_in_x    = (DrawX >= sprite_x) && (w_dx < 11'(SPR_W));
        w_in_y    = (DrawY >= sprite_y) && (w_dy < 11'(SPR_H));
        w_inbox   = w_in_x && w_in_y;
        w_col     = flip ? (ADDR_W'(SPR_W - 1) - ADDR_W'(w_dx)) : ADDR_W'(w_dx);
        w_row_off = ADDR_W'(w_dy) * ADDR_W'(SPR_W);
        w_base    = ADDR_W'(w_disp_frame) * ADDR_W'(FRAME_PIX);
        w_addr    = w_inbox ? (w_base + w_row_off + w_col) : '0;
    end

    // Stage p1: ROM address and in-box flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr_p1 <= '0;
            r_vld_p1      <= 1'b0;
        end else begin
            r_rom_addr_p1 <= w_addr;
            r_vld_p1      <= w_inbox;
        end
    end

    // Stage p2: in-box flag aligned with rom_data
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign w_pix_vld = r_vld_p2 && (rom_data != TRANSPARENT_IDX);

    // Stage p3: palette index out
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pix_index_p3 <= TRANSPARENT_IDX;
            r_pix_valid_p3 <= 1'b0;
        end else begin
            r_pix_index_p3 <= w_pix_vld ? rom_data : TRANSPARENT_IDX;
            r_pix_valid_p3 <= w_pix_vld;
        end
    end

    assign rom_addr  = r_rom_addr_p1;
    assign pix_index = r_pix_index_p3;
    assign pix_valid = r_pix_valid_p3;

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Directed bench for sprite_index_fetch with a registered index-ROM model.
module tb_sprite_index_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
    logic        frame_start, flip, hit_trig;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data = 4'h0;
    logic [3:0]  pix_index;
    logic        pix_valid, anim_busy;
    logic        rom_tr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    sprite_index_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .flip        (flip),
        .hit_trig    (hit_trig),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_index   (pix_index),
        .pix_valid   (pix_valid),
        .anim_busy   (anim_busy)
    );

    always #5 Clk = ~Clk;

    // ROM model: data = (addr + 3) mod 15, never transparent unless forced.
    always @(posedge Clk) begin
        rom_data <= rom_tr ? 4'hF : 4'(({17'd0, rom_addr} + 32'd3) % 32'd15);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic fs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
    endtask

    task automatic set_pos(input int x, input int y, input logic f);
        DrawX = 10'(x);
        DrawY = 10'(y);
        flip  = f;
    endtask

    initial begin
        Reset_n = 1'b0;
        frame_start = 1'b0;
        hit_trig = 1'b0;
        sprite_x = 10'd100;
        sprite_y = 10'd50;
        set_pos(100, 50, 1'b0);
        step();
        step();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_pix_index", pix_index, 15);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_anim_busy", anim_busy, 0);

        // Origin pixel, latency and no early valid after reset release
        Reset_n = 1'b1;
        step();
        chk("origin_addr", rom_addr, 0);
        chk("origin_vld_t1", pix_valid, 0);
        step();
        chk("origin_vld_t2", pix_valid, 0);
        step();
        chk("origin_vld_t3", pix_valid, 1);
        chk("origin_idx_t3", pix_index, 3);

        set_pos(105, 52, 1'b0);
        step();
        chk("noflip_addr", rom_addr, 133);
        step();
        step();
        chk("noflip_idx", pix_index, 1);

        // Mirrored
        set_pos(100, 51, 1'b1);
        step();
        chk("flip_left_addr", rom_addr, 127);
        set_pos(163, 51, 1'b1);
        step();
        chk("flip_right_addr", rom_addr, 64);
        set_pos(164, 51, 1'b1);
        step();
        chk("flip_out_addr", rom_addr, 0);
        step();
        step();
        chk("flip_out_vld", pix_valid, 0);
        chk("flip_out_idx", pix_index, 15);

        // Transparent ROM index inside the box
        rom_tr = 1'b1;
        set_pos(110, 60, 1'b0);
        step();
        chk("tr_addr", rom_addr, 650);
        step();
        step();
        chk("tr_vld", pix_valid, 0);
        chk("tr_idx", pix_index, 15);
        rom_tr = 1'b0;

        // Right-edge sprite: no wrap
        sprite_x = 10'd1000;
        set_pos(1010, 50, 1'b0);
        step();
        chk("edge_addr", rom_addr, 10);
        step();
        step();
        chk("edge_vld", pix_valid, 1);
        chk("edge_idx", pix_index, 13);
        set_pos(5, 50, 1'b0);
        step();
        chk("wrap_addr", rom_addr, 0);
        step();
        step();
        chk("wrap_vld", pix_valid, 0);

        // Animation run
        sprite_x = 10'd100;
        set_pos(100, 50, 1'b0);
        hit_trig = 1'b1;
        step();
        hit_trig = 1'b0;
        step();
        chk("anim_busy_start", anim_busy, 1);
        fs_pulses(5);
        chk("anim_f0_addr", rom_addr, 0);
        fs_pulses(1);
        chk("anim_f1_addr", rom_addr, 6144);
        fs_pulses(17);
        chk("anim_f3_addr", rom_addr, 18432);
        chk("anim_f3_busy", anim_busy, 1);
        fs_pulses(1);
        chk("anim_end_busy", anim_busy, 0);
        chk("anim_end_addr", rom_addr, 0);

        // Retrigger coincident with the 5th frame_start of frame 2
        hit_trig = 1'b1;
        step();
        hit_trig = 1'b0;
        fs_pulses(12);
        chk("re_f2_addr", rom_addr, 12288);
        fs_pulses(4);
        hit_trig = 1'b1;
        frame_start = 1'b1;
        step();
        hit_trig = 1'b0;
        frame_start = 1'b0;
        step();
        chk("re_busy", anim_busy, 1);
        chk("re_addr", rom_addr, 0);
        fs_pulses(5);
        chk("re_tick5_addr", rom_addr, 0);
        fs_pulses(1);
        chk("re_f1_addr", rom_addr, 6144);
        step();
        step();
        chk("re_f1_vld", pix_valid, 1);
        chk("re_f1_idx", pix_index, 12);

        // Asynchronous reset mid-cycle while playing
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_pix_index", pix_index, 15);
        chk("arst_pix_valid", pix_valid, 0);
        chk("arst_anim_busy", anim_busy, 0);
        step();
        Reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
